// File: rtl/fetch_inst_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue.
// The queue uses the slave view; fetch/decode (or a bench) uses the master view.
interface fetch_inst_queue_if #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned PC_W  = 64,
   parameter int unsigned CNT_W = $clog2(DEPTH) + 1
);
   logic             flush_i;
   logic             fetch_valid_i;
   logic [1:0]       fetch_slot_vld_i;
   logic [PC_W-1:0]  fetch_pc_i;
   logic [31:0]      fetch_inst0_i;
   logic [31:0]      fetch_inst1_i;
   logic             fetch_ready_o;
   logic             pipe_load_decode_i;
   logic             dec_vld0_o;
   logic [31:0]      dec_inst0_o;
   logic [PC_W-1:0]  dec_pc0_o;
   logic             dec_vld1_o;
   logic [31:0]      dec_inst1_o;
   logic [PC_W-1:0]  dec_pc1_o;
   logic [CNT_W-1:0] count_o;

   modport master (
      output flush_i, fetch_valid_i, fetch_slot_vld_i, fetch_pc_i, fetch_inst0_i,
             fetch_inst1_i, pipe_load_decode_i,
      input  fetch_ready_o, dec_vld0_o, dec_inst0_o, dec_pc0_o, dec_vld1_o, dec_inst1_o,
             dec_pc1_o, count_o
   );

   modport slave (
      input  flush_i, fetch_valid_i, fetch_slot_vld_i, fetch_pc_i, fetch_inst0_i,
             fetch_inst1_i, pipe_load_decode_i,
      output fetch_ready_o, dec_vld0_o, dec_inst0_o, dec_pc0_o, dec_vld1_o, dec_inst1_o,
             dec_pc1_o, count_o
   );
endinterface

// File: rtl/fetch_inst_queue.sv
// Instruction queue between fetch and the two decode ways.
// Circular buffer taking up to two instructions per cycle and presenting the
// oldest two entries to decode; flush empties it without clearing storage.
module fetch_inst_queue #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned PC_W  = 64,
   parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input logic              clock,
   input logic              reset,
   fetch_inst_queue_if.slave bus
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [31:0]      inst_mem [DEPTH];
   logic [PC_W-1:0]  pc_mem   [DEPTH];

   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [PTR_W-1:0] head_nxt, tail_nxt;
   logic [CNT_W-1:0] count_q, count_d;
   logic             vld0, vld1, ready;
   logic             push_en, wr0, wr1;
   logic [1:0]       push_n, pop_n;

   // Decode-side view and ready, all from registered state only.
   always_comb begin
      head_nxt          = head_q + PTR_W'(1);
      tail_nxt          = tail_q + PTR_W'(1);
      vld0              = (count_q != '0);
      vld1              = (count_q >= CNT_W'(2));
      ready             = (count_q <= CNT_W'(DEPTH - 2));
      bus.dec_vld0_o    = vld0;
      bus.dec_vld1_o    = vld1;
      bus.dec_inst0_o   = inst_mem[head_q];
      bus.dec_pc0_o     = pc_mem[head_q];
      bus.dec_inst1_o   = inst_mem[head_nxt];
      bus.dec_pc1_o     = pc_mem[head_nxt];
      bus.fetch_ready_o = ready;
      bus.count_o       = count_q;
   end

   // Push/pop amounts and next pointers; flush overrides everything.
   always_comb begin
      pop_n = 2'd0;
      if (bus.pipe_load_decode_i && !bus.flush_i) begin
         pop_n = {1'b0, vld0} + {1'b0, vld1};
      end
      // Slot-valid 2'b10 has no slot 0, so nothing is written.
      push_en = bus.fetch_valid_i & ready & ~bus.flush_i;
      wr0     = push_en & bus.fetch_slot_vld_i[0];
      wr1     = wr0 & bus.fetch_slot_vld_i[1];
      push_n  = {1'b0, wr0} + {1'b0, wr1};
      if (bus.flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + PTR_W'(pop_n);
         tail_d  = tail_q + PTR_W'(push_n);
         count_d = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage; slot 1 lands at tail+1 with PC + 4.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            inst_mem[i] <= '0;
            pc_mem[i]   <= '0;
         end
      end else begin
         if (wr0) begin
            inst_mem[tail_q] <= bus.fetch_inst0_i;
            pc_mem[tail_q]   <= bus.fetch_pc_i;
         end
         if (wr1) begin
            inst_mem[tail_nxt] <= bus.fetch_inst1_i;
            pc_mem[tail_nxt]   <= bus.fetch_pc_i + PC_W'(4);
         end
      end
   end

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Self-checking bench for fetch_inst_queue: directed scenarios followed by
// random traffic, compared against a queue-based reference model.
module tb_fetch_inst_queue;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned PC_W  = 64;

   typedef struct packed {
      logic [31:0]     inst;
      logic [PC_W-1:0] pc;
   } ent_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;
   ent_t q[$];

   fetch_inst_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus ();

   fetch_inst_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Compare every output against the model's view of the queue.
   task automatic check_outputs();
      int n;
      n = q.size();
      chk("count", 64'(bus.count_o), 64'(n));
      chk("vld0", 64'(bus.dec_vld0_o), 64'(n >= 1));
      chk("vld1", 64'(bus.dec_vld1_o), 64'(n >= 2));
      chk("ready", 64'(bus.fetch_ready_o), 64'((DEPTH - n) >= 2));
      if (n >= 1) begin
         chk("inst0", 64'(bus.dec_inst0_o), 64'(q[0].inst));
         chk("pc0", bus.dec_pc0_o, q[0].pc);
      end
      if (n >= 2) begin
         chk("inst1", 64'(bus.dec_inst1_o), 64'(q[1].inst));
         chk("pc1", bus.dec_pc1_o, q[1].pc);
      end
   endtask

   // One clock: drive inputs at the falling edge, check, then apply the
   // model's rules for what the rising edge does.
   task automatic cycle(input logic fl, input logic v, input logic [1:0] sv,
                        input logic [PC_W-1:0] pc, input logic [31:0] a,
                        input logic [31:0] b, input logic ld);
      bit rdy;
      int npop;
      bus.flush_i            = fl;
      bus.fetch_valid_i      = v;
      bus.fetch_slot_vld_i   = sv;
      bus.fetch_pc_i         = pc;
      bus.fetch_inst0_i      = a;
      bus.fetch_inst1_i      = b;
      bus.pipe_load_decode_i = ld;
      check_outputs();
      rdy = (DEPTH - q.size()) >= 2;
      @(posedge clock);
      if (fl) begin
         q.delete();
      end else begin
         npop = ld ? ((q.size() >= 2) ? 2 : q.size()) : 0;
         for (int i = 0; i < npop; i++) void'(q.pop_front());
         if (v && rdy && sv[0]) begin
            q.push_back('{inst: a, pc: pc});
            if (sv[1]) q.push_back('{inst: b, pc: pc + PC_W'(4)});
         end
      end
      @(negedge clock);
   endtask

   task automatic push(input logic [1:0] sv, input logic [PC_W-1:0] pc,
                       input logic [31:0] a, input logic [31:0] b);
      cycle(1'b0, 1'b1, sv, pc, a, b, 1'b0);
   endtask

   task automatic pop();
      cycle(1'b0, 1'b0, 2'b00, '0, '0, '0, 1'b1);
   endtask

   initial begin
      bus.flush_i            = 1'b0;
      bus.fetch_valid_i      = 1'b0;
      bus.fetch_slot_vld_i   = 2'b00;
      bus.fetch_pc_i         = '0;
      bus.fetch_inst0_i      = '0;
      bus.fetch_inst1_i      = '0;
      bus.pipe_load_decode_i = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;

      // Reset-state outputs, including zeroed storage.
      chk("rst_inst0", 64'(bus.dec_inst0_o), 64'h0);
      chk("rst_pc1", bus.dec_pc1_o, 64'h0);
      check_outputs();

      // 1: reset asserted mid-fill clears immediately.
      push(2'b11, 64'h500, 32'h5000_0000, 32'h5000_0001);
      push(2'b11, 64'h508, 32'h5000_0002, 32'h5000_0003);
      push(2'b01, 64'h510, 32'h5000_0004, 32'h0);
      chk("mid_count5", 64'(bus.count_o), 64'd5);
      #2 reset = 1'b1;
      #1;
      q.delete();
      chk("async_count", 64'(bus.count_o), 64'd0);
      chk("async_vld0", 64'(bus.dec_vld0_o), 64'd0);
      chk("async_vld1", 64'(bus.dec_vld1_o), 64'd0);
      chk("async_inst0", 64'(bus.dec_inst0_o), 64'd0);
      chk("async_ready", 64'(bus.fetch_ready_o), 64'd1);
      @(negedge clock);
      reset = 1'b0;

      // 2: fill to DEPTH, extra group is dropped.
      for (int k = 0; k < 4; k++) begin
         push(2'b11, 64'h1000 + 64'(8 * k), 32'h1100_0000 + 32'(2 * k),
              32'h1100_0001 + 32'(2 * k));
      end
      chk("fill_count", 64'(bus.count_o), 64'd8);
      chk("fill_ready", 64'(bus.fetch_ready_o), 64'd0);
      push(2'b11, 64'h1020, 32'hBAD0_0000, 32'hBAD0_0001);
      chk("drop_count", 64'(bus.count_o), 64'd8);
      chk("fill_pc1", bus.dec_pc1_o, 64'h1004);

      // 3: drain, then a lone single-slot entry pops alone.
      repeat (4) pop();
      push(2'b01, 64'h2000, 32'h0000_0013, 32'hFFFF_FFFF);
      chk("odd_vld1", 64'(bus.dec_vld1_o), 64'd0);
      chk("odd_inst0", 64'(bus.dec_inst0_o), 64'h13);
      pop();
      chk("odd_count", 64'(bus.count_o), 64'd0);

      // 4: simultaneous push of two and pop of two at count 3.
      push(2'b11, 64'h3000, 32'hA0, 32'hA1);
      push(2'b01, 64'h3008, 32'hA2, 32'h0);
      cycle(1'b0, 1'b1, 2'b11, 64'h300C, 32'hB0, 32'hB1, 1'b1);
      chk("sim_count", 64'(bus.count_o), 64'd3);
      chk("sim_inst0", 64'(bus.dec_inst0_o), 64'hA2);

      // 5: flush beats same-cycle push and pop.
      push(2'b11, 64'h3100, 32'hC0, 32'hC1);
      push(2'b01, 64'h3108, 32'hC2, 32'h0);
      chk("pre_flush_count", 64'(bus.count_o), 64'd6);
      cycle(1'b1, 1'b1, 2'b11, 64'h3200, 32'hEE, 32'hEF, 1'b1);
      chk("flush_count", 64'(bus.count_o), 64'd0);
      chk("flush_vld0", 64'(bus.dec_vld0_o), 64'd0);
      chk("flush_ready", 64'(bus.fetch_ready_o), 64'd1);
      push(2'b01, 64'h3300, 32'hD0, 32'h0);
      chk("post_flush_inst0", 64'(bus.dec_inst0_o), 64'hD0);
      chk("post_flush_pc0", bus.dec_pc0_o, 64'h3300);

      // 6: wrap; head = tail = DEPTH-1, then a two-slot push straddles 7/0.
      cycle(1'b1, 1'b0, 2'b00, '0, '0, '0, 1'b0);
      for (int k = 0; k < 7; k++) begin
         push(2'b01, 64'h4000 + 64'(4 * k), 32'hE0 + 32'(k), 32'h0);
         pop();
      end
      push(2'b11, 64'h5000, 32'hDEAD_BEEF, 32'hCAFE_F00D);
      chk("wrap_inst0", 64'(bus.dec_inst0_o), 64'hDEAD_BEEF);
      chk("wrap_inst1", 64'(bus.dec_inst1_o), 64'hCAFE_F00D);
      chk("wrap_pc0", bus.dec_pc0_o, 64'h5000);
      chk("wrap_pc1", bus.dec_pc1_o, 64'h5004);
      pop();

      // Random traffic against the model, including PC carry-out at the top.
      for (int k = 0; k < 400; k++) begin
         logic [PC_W-1:0] rpc;
         logic [1:0]      rsv;
         rpc = {$urandom, $urandom};
         if ($urandom_range(0, 7) == 0) rpc = '1 - PC_W'($urandom_range(0, 8));
         rsv = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b01;
         cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), rsv, rpc,
               $urandom, $urandom, ($urandom_range(0, 2) == 0));
      end
      check_outputs();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_inst_queue.md
Name: fetch_inst_queue

Overview:
- Instruction queue between the fetch stage and the two decode ways.
- Accepts up to two 32-bit instructions per cycle from fetch, together with their PCs, into a circular buffer.
- Presents the oldest two entries to decode way 0 and way 1.
- Pops them when decode asserts pipe_load_decode_i.
- Flushed on redirect (branch mispredict or exception).

Parameters:
- DEPTH, 8, number of entries; power of 2, at least 4.
- PC_W, 64, PC width in bits.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- clock  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush_i  in  1  discard all entries; has priority over push and pop.
- fetch_valid_i  in  1  fetch group present this cycle.
- fetch_slot_vld_i  in  2  per-slot valid; legal values 2'b01 and 2'b11.
- fetch_pc_i  in  PC_W  PC of slot 0; slot 1 PC = fetch_pc_i + 4.
- fetch_inst0_i  in  32  slot 0 instruction (older).
- fetch_inst1_i  in  32  slot 1 instruction.
- fetch_ready_o  out  1  queue can accept a full two-slot group.
- pipe_load_decode_i  in  1  decode consumes all currently valid output slots.
- dec_vld0_o  out  1  way 0 slot holds a valid instruction.
- dec_inst0_o  out  32  way 0 instruction, i.e. the head entry.
- dec_pc0_o  out  PC_W  way 0 PC.
- dec_vld1_o  out  1  way 1 slot holds a valid instruction.
- dec_inst1_o  out  32  way 1 instruction, i.e. head+1.
- dec_pc1_o  out  PC_W  way 1 PC.
- count_o  out  CNT_W  current occupancy.

Behaviour:
- Storage
  - DEPTH entries, each {inst[31:0], pc[PC_W-1:0]}.
  - Registered head pointer, tail pointer and count.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Reset (asynchronous)
  - head = 0, tail = 0, count = 0.
  - All storage entries = 0.
  - Resulting outputs: dec_vld0_o = dec_vld1_o = 0, all dec_inst/dec_pc outputs = 0, count_o = 0, fetch_ready_o = 1.
  - Reset asserted mid-operation discards all contents immediately.
- Output slots (combinational from registered state; no added latency)
  - dec_vld0_o = (count >= 1); dec_vld1_o = (count >= 2).
  - dec_inst0_o/dec_pc0_o = entry[head]; dec_inst1_o/dec_pc1_o = entry[head+1 mod DEPTH].
  - Data outputs are driven regardless of the valid bits.
- Pop
  - When pipe_load_decode_i = 1 and flush_i = 0: pop_n = dec_vld0_o + dec_vld1_o (0, 1 or 2).
  - head += pop_n, modulo DEPTH.
  - pipe_load_decode_i with count = 0 is a no-op.
- Push
  - push_en = fetch_valid_i & fetch_ready_o & ~flush_i.
  - fetch_slot_vld_i = 2'b01: write slot 0 at tail; push_n = 1.
  - fetch_slot_vld_i = 2'b11: write slot 0 at tail and slot 1 at tail+1; push_n = 2.
  - Slot 1 PC is stored as fetch_pc_i + 4, truncated to PC_W.
  - 2'b00 and 2'b10: nothing written, push_n = 0.
  - tail += push_n, modulo DEPTH.
  - A push attempted while fetch_ready_o = 0 is dropped. Fetch must hold its group until ready.
- Ready
  - fetch_ready_o = (DEPTH - count >= 2), computed from registered count only.
  - It does not account for a same-cycle pop; no combinational path from pipe_load_decode_i.
- Count update
  - count_next = count + push_n - pop_n.
  - Push and pop in the same cycle are both applied. Pushed entries never appear on outputs in the cycle they are written; they become visible on the next cycle.
  - count never exceeds DEPTH, guaranteed by the ready rule.
- Flush
  - flush_i = 1: next cycle head = tail = 0 and count = 0.
  - Any same-cycle push and pop are ignored.
  - Storage contents are not cleared.
  - Outputs show vld = 0 from the following cycle.
- Wrap-around
  - Two-slot writes and the head+1 read wrap naturally, e.g. tail = DEPTH-1 writes entries DEPTH-1 and 0.

Test Plan:
1. Reset then idle: assert reset mid-fill with count = 5 -> same cycle count_o = 0, dec_vld0_o = dec_vld1_o = 0, dec_inst0_o = 0, fetch_ready_o = 1.
2. Fill: 4 cycles of two-slot pushes (PC 0x1000, 0x1008, ...), no pops -> count_o = 8, fetch_ready_o = 0. A fifth group is dropped and count stays 8. dec_pc1_o = 0x1004.
3. Odd drain: push one single-slot group (inst 0x00000013, PC 0x2000), then pulse pipe_load_decode_i -> dec_vld1_o = 0, one entry popped, count_o = 0.
4. Simultaneous: with count = 3, push two and pop in the same cycle -> count_o = 3. The new head is the old entry 2, so its data appears on way 0.
5. Flush priority: with count = 6, assert flush_i together with a push and pop -> next cycle count_o = 0, vld outputs = 0, fetch_ready_o = 1. A subsequent push lands at entry 0.
6. Wrap: drive head = tail = 7 via 7 single pushes and 7 pops, then push 2'b11 (inst A, B) -> entry 7 = A, entry 0 = B. Outputs show A on way 0 and B on way 1 with PCs pc and pc+4.
